// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: load/use, mispredict and ret hazards plus a RUN/DRAIN/HALT sequencer.
// Optional saturating performance counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_Stat,
   input  logic [3:0]       W_Stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             halted,
   output logic [3:0]       status,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [3:0] STAT_AOK   = 4'h8;
   localparam logic [3:0] REG_NONE   = 4'hF;
   localparam logic [3:0] I_MRMOVQ   = 4'h5;
   localparam logic [3:0] I_OPQ      = 4'h6;
   localparam logic [3:0] I_JXX      = 4'h7;
   localparam logic [3:0] I_RET      = 4'h9;
   localparam logic [3:0] I_POPQ     = 4'hB;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] status_nxt;

   logic loaduse;
   logic mispred;
   logic retp;
   logic m_exc;
   logic w_exc;
   logic exc;

   assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                    (E_dstM != REG_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign mispred = (E_icode == I_JXX) && !e_Cnd;
   assign retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign m_exc   = (m_Stat != STAT_AOK);
   assign w_exc   = (W_Stat != STAT_AOK);
   assign exc     = m_exc || w_exc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         status <= STAT_AOK;
      end else begin
         state  <= state_nxt;
         status <= status_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      status_nxt = status;
      F_stall    = 1'b0;
      D_stall    = 1'b0;
      D_bubble   = 1'b0;
      E_bubble   = 1'b0;
      M_bubble   = 1'b0;
      W_stall    = 1'b0;
      set_cc     = 1'b0;
      halted     = 1'b0;
      case (state)
         IDLE: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            F_stall  = loaduse | retp;
            // A mispredict squashes D, so a simultaneous load/use must not also hold it.
            D_stall  = loaduse & ~mispred;
            D_bubble = mispred | (retp & ~loaduse);
            E_bubble = mispred | loaduse;
            M_bubble = exc;
            W_stall  = w_exc;
            set_cc   = (E_icode == I_OPQ) & ~exc;
            if (w_exc) begin
               state_nxt  = HALT;
               status_nxt = W_Stat;
            end else if (m_exc) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            if (w_exc) begin
               state_nxt  = HALT;
               status_nxt = W_Stat;
            end
         end
         HALT: begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            W_stall = 1'b1;
            halted  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic active;
   assign active = (state == RUN) || (state == DRAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt     <= '0;
         stall_cnt   <= '0;
         mispred_cnt <= '0;
      end else begin
         if (active && (cyc_cnt != CNT_MAX))
            cyc_cnt <= cyc_cnt + CNT_ONE;
         if ((state == RUN) && F_stall && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_ONE;
         if ((state == RUN) && mispred && (mispred_cnt != CNT_MAX))
            mispred_cnt <= mispred_cnt + CNT_ONE;
      end
   end
`else
   assign cyc_cnt     = '0;
   assign stall_cnt   = '0;
   assign mispred_cnt = '0;
`endif

endmodule
